// File: rtl/sram_pipe_decode_stage_if.sv
// Bundle between the upstream pipeline and the SRAM decode stage: stage controls,
// binary request fields, and the decoded word-line / write / bypass results.
interface sram_pipe_decode_stage_if #(
    parameter int SRAM_DEPTH = 64,
    parameter int SRAM_INDEX = 6,
    parameter int SRAM_WIDTH = 8,
    parameter int NUM_RD     = 12,
    parameter int NUM_WR     = 6
);
    logic                           stall_i;
    logic                           flush_i;
    logic [NUM_RD-1:0]              rd_valid_i;
    logic [NUM_RD*SRAM_INDEX-1:0]   rd_addr_i;
    logic [NUM_WR-1:0]              we_i;
    logic [NUM_WR*SRAM_INDEX-1:0]   wr_addr_i;
    logic [NUM_WR*SRAM_WIDTH-1:0]   wr_data_i;

    logic [NUM_RD*SRAM_DEPTH-1:0]   decoded_rd_addr_o;
    logic [NUM_WR*SRAM_DEPTH-1:0]   decoded_wr_addr_o;
    logic [NUM_WR-1:0]              we_o;
    logic [NUM_WR*SRAM_WIDTH-1:0]   wr_data_o;
    logic [NUM_RD-1:0]              rd_byp_valid_o;
    logic [NUM_RD*SRAM_WIDTH-1:0]   rd_byp_data_o;
    logic                           addr_err_o;

    modport master (
        output stall_i, flush_i, rd_valid_i, rd_addr_i, we_i, wr_addr_i, wr_data_i,
        input  decoded_rd_addr_o, decoded_wr_addr_o, we_o, wr_data_o,
               rd_byp_valid_o, rd_byp_data_o, addr_err_o
    );

    modport slave (
        input  stall_i, flush_i, rd_valid_i, rd_addr_i, we_i, wr_addr_i, wr_data_i,
        output decoded_rd_addr_o, decoded_wr_addr_o, we_o, wr_data_o,
               rd_byp_valid_o, rd_byp_data_o, addr_err_o
    );
endinterface

// File: rtl/sram_pipe_decode_stage.sv
// Registered address/data stage in front of the multi-ported SRAM: one-hot decode,
// last-writer-wins collision resolution and same-cycle read bypass.
module sram_pipe_decode_stage #(
    parameter int SRAM_DEPTH = 64,
    parameter int SRAM_INDEX = 6,
    parameter int SRAM_WIDTH = 8,
    parameter int NUM_RD     = 12,
    parameter int NUM_WR     = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    sram_pipe_decode_stage_if.slave  bus
);
    // One extra bit so that SRAM_DEPTH == 2**SRAM_INDEX is representable.
    localparam logic [SRAM_INDEX:0] DEPTH_LIM = (SRAM_INDEX+1)'(SRAM_DEPTH);

    logic [NUM_RD-1:0]       rd_valid_reg;
    logic [SRAM_INDEX-1:0]   rd_addr_reg [NUM_RD];
    logic [NUM_WR-1:0]       we_reg;
    logic [SRAM_INDEX-1:0]   wr_addr_reg [NUM_WR];
    logic [SRAM_WIDTH-1:0]   wr_data_reg [NUM_WR];

    logic [NUM_RD-1:0]       rd_in_range;
    logic [NUM_WR-1:0]       wr_in_range;
    logic [NUM_WR-1:0]       wr_cand;
    logic [NUM_WR-1:0]       we_eff;
    logic [NUM_RD-1:0]       byp_valid;
    logic [SRAM_WIDTH-1:0]   byp_data [NUM_RD];

    logic capture;
    assign capture = !bus.flush_i && !bus.stall_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_reg <= '0;
            we_reg       <= '0;
        end else if (bus.flush_i) begin
            rd_valid_reg <= '0;
            we_reg       <= '0;
        end else if (!bus.stall_i) begin
            rd_valid_reg <= bus.rd_valid_i;
            we_reg       <= bus.we_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            always_ff @(posedge clk) begin
                if (reset)
                    rd_addr_reg[gi] <= '0;
                else if (capture)
                    rd_addr_reg[gi] <= bus.rd_addr_i[gi*SRAM_INDEX +: SRAM_INDEX];
            end

            assign rd_in_range[gi] = {1'b0, rd_addr_reg[gi]} < DEPTH_LIM;
            assign bus.decoded_rd_addr_o[gi*SRAM_DEPTH +: SRAM_DEPTH] =
                (rd_valid_reg[gi] && rd_in_range[gi]) ? (SRAM_DEPTH'(1) << rd_addr_reg[gi]) : '0;
            assign bus.rd_byp_data_o[gi*SRAM_WIDTH +: SRAM_WIDTH] = byp_data[gi];
        end

        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_addr_reg[gi] <= '0;
                    wr_data_reg[gi] <= '0;
                end else if (capture) begin
                    wr_addr_reg[gi] <= bus.wr_addr_i[gi*SRAM_INDEX +: SRAM_INDEX];
                    wr_data_reg[gi] <= bus.wr_data_i[gi*SRAM_WIDTH +: SRAM_WIDTH];
                end
            end

            assign wr_in_range[gi] = {1'b0, wr_addr_reg[gi]} < DEPTH_LIM;
            assign wr_cand[gi]     = we_reg[gi] && wr_in_range[gi];
            assign bus.decoded_wr_addr_o[gi*SRAM_DEPTH +: SRAM_DEPTH] =
                we_eff[gi] ? (SRAM_DEPTH'(1) << wr_addr_reg[gi]) : '0;
            assign bus.wr_data_o[gi*SRAM_WIDTH +: SRAM_WIDTH] = wr_data_reg[gi];
        end
    endgenerate

    // A candidate is suppressed by any higher-numbered candidate on the same index.
    always_comb begin
        we_eff = wr_cand;
        for (int w = 0; w < NUM_WR; w++) begin
            for (int k = w + 1; k < NUM_WR; k++) begin
                if (wr_cand[k] && (wr_addr_reg[k] == wr_addr_reg[w]))
                    we_eff[w] = 1'b0;
            end
        end
    end

    // Winners are unique per index, so OR-ing the hit data selects exactly one word.
    always_comb begin
        byp_valid = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            byp_data[r] = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (rd_valid_reg[r] && we_eff[w] && (wr_addr_reg[w] == rd_addr_reg[r])) begin
                    byp_valid[r] = 1'b1;
                    byp_data[r]  = byp_data[r] | wr_data_reg[w];
                end
            end
        end
    end

    assign bus.we_o           = we_eff;
    assign bus.rd_byp_valid_o = byp_valid;
    assign bus.addr_err_o     = (|(rd_valid_reg & ~rd_in_range)) || (|(we_reg & ~wr_in_range));
endmodule
